// File: rtl/core_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : core_run_monitor
// Description : Run monitor for the multi-core matrix-multiplication CPU.
//               Latches the first finish cycle of every core, reports overall
//               completion and raises a watchdog timeout when a run exceeds
//               TIMEOUT_CYCLES.
//               Optional per-core command-change statistics are built when
//               the macro CORE_RUN_MONITOR_CMD_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module core_run_monitor #(
   parameter int NUM_CORES      = 4,        // 1..16
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 1500000,  // >= 2 and < 2**CNT_W
   parameter int CMD_W          = 6
) (
   input  logic                       MAIN_CLOCK,
   input  logic                       RESET,
   input  logic                       START,
   input  logic [NUM_CORES-1:0]       PROCESS_DONE,
`ifdef CORE_RUN_MONITOR_CMD_STATS_EN
   input  logic [NUM_CORES*CMD_W-1:0] CMD,
`endif
   input  logic [3:0]                 RD_SEL,
   output logic                       BUSY,
   output logic                       ALL_DONE,
   output logic                       TIMEOUT,
   output logic [NUM_CORES-1:0]       CORE_DONE_MASK,
   output logic [CNT_W-1:0]           CYCLE_COUNT,
`ifdef CORE_RUN_MONITOR_CMD_STATS_EN
   output logic [15:0]                CMD_CHANGES,
`endif
   output logic [CNT_W-1:0]           FINISH_CYCLE
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      DONE      = 2'd2,
      TIMED_OUT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]     LIMIT    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_CORES-1:0] ALL_ONES = {NUM_CORES{1'b1}};

   state_t                 state;
   logic [NUM_CORES-1:0]   capture;     // cores finishing on this edge
   logic [NUM_CORES-1:0]   mask_next;   // mask as it will be after this edge
   logic                   start_ok;    // START accepted (ignored while running)
   logic [CNT_W-1:0]       finish [NUM_CORES];
   logic [CNT_W-1:0]       finish_sel;

   // Newly finishing cores and the accepted-start qualifier.
   always_comb begin
      capture   = '0;
      if (state == RUN) begin
         capture = PROCESS_DONE & ~CORE_DONE_MASK;
      end
      mask_next = CORE_DONE_MASK | capture;
      start_ok  = START && (state != RUN);
   end

   // Run-control FSM with its cycle counter, done mask and status flags.
   always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
      if (RESET) begin
         state          <= IDLE;
         CYCLE_COUNT    <= '0;
         CORE_DONE_MASK <= '0;
         BUSY           <= 1'b0;
         ALL_DONE       <= 1'b0;
         TIMEOUT        <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               CORE_DONE_MASK <= mask_next;
               CYCLE_COUNT    <= CYCLE_COUNT + 1'b1;
               // Completion takes priority over the budget limit on the same edge.
               if (mask_next == ALL_ONES) begin
                  state    <= DONE;
                  BUSY     <= 1'b0;
                  ALL_DONE <= 1'b1;
               end else if (CYCLE_COUNT == LIMIT) begin
                  state    <= TIMED_OUT;
                  BUSY     <= 1'b0;
                  TIMEOUT  <= 1'b1;
               end
            end
            default: begin
               // IDLE, DONE and TIMED_OUT all (re)start on START.
               if (START) begin
                  state          <= RUN;
                  CYCLE_COUNT    <= '0;
                  CORE_DONE_MASK <= '0;
                  BUSY           <= 1'b1;
                  ALL_DONE       <= 1'b0;
                  TIMEOUT        <= 1'b0;
               end
            end
         endcase
      end
   end

   // Per-core finish timestamps: captured once per run, cleared on start.
   always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            finish[i] <= '0;
         end
      end else if (start_ok) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            finish[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (capture[i]) begin
               finish[i] <= CYCLE_COUNT;
            end
         end
      end
   end

   // Timestamp select; out-of-range indices read as zero.
   always_comb begin
      finish_sel = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (RD_SEL == 4'(i)) begin
            finish_sel = finish[i];
         end
      end
   end

   // Registered timestamp readout (one-cycle latency from RD_SEL).
   always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
      if (RESET) begin
         FINISH_CYCLE <= '0;
      end else begin
         FINISH_CYCLE <= finish_sel;
      end
   end

`ifdef CORE_RUN_MONITOR_CMD_STATS_EN
   logic [CMD_W-1:0] cmd_prev [NUM_CORES];
   logic [15:0]      cmd_cnt  [NUM_CORES];
   logic [15:0]      cmd_sel;

   // Command-change counters: previous value loaded on start so the first
   // RUN edge never counts; a core stops counting once it has finished.
   always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            cmd_prev[i] <= '0;
            cmd_cnt[i]  <= '0;
         end
      end else if (start_ok) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            cmd_prev[i] <= CMD[i*CMD_W +: CMD_W];
            cmd_cnt[i]  <= '0;
         end
      end else if (state == RUN) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            cmd_prev[i] <= CMD[i*CMD_W +: CMD_W];
            if (!CORE_DONE_MASK[i] && (CMD[i*CMD_W +: CMD_W] != cmd_prev[i]) &&
                (cmd_cnt[i] != 16'hFFFF)) begin
               cmd_cnt[i] <= cmd_cnt[i] + 16'd1;
            end
         end
      end
   end

   // Counter select; out-of-range indices read as zero.
   always_comb begin
      cmd_sel = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (RD_SEL == 4'(i)) begin
            cmd_sel = cmd_cnt[i];
         end
      end
   end

   // Registered counter readout (one-cycle latency from RD_SEL).
   always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
      if (RESET) begin
         CMD_CHANGES <= '0;
      end else begin
         CMD_CHANGES <= cmd_sel;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_run_monitor
// Description : Directed scoreboard bench for core_run_monitor
//               (NUM_CORES=4, TIMEOUT_CYCLES=50).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_run_monitor;
   localparam int NUM_CORES      = 4;
   localparam int CNT_W          = 32;
   localparam int TIMEOUT_CYCLES = 50;
   localparam int CMD_W          = 6;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [NUM_CORES-1:0] pd;
   logic [3:0]           rd_sel;
   logic                 busy, all_done, timeout;
   logic [NUM_CORES-1:0] mask;
   logic [CNT_W-1:0]     cyc, fin;
`ifdef CORE_RUN_MONITOR_CMD_STATS_EN
   logic [NUM_CORES*CMD_W-1:0] cmd;
   logic [15:0]                chg;
`endif

   string       tag_q[$];
   logic [31:0] val_q[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          e          = 0;   // RUN edges elapsed in the current run

   always #5 clk = ~clk;

   core_run_monitor #(
      .NUM_CORES(NUM_CORES), .CNT_W(CNT_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CMD_W(CMD_W)
   ) dut (
      .MAIN_CLOCK(clk),
      .RESET(rst),
      .START(start),
      .PROCESS_DONE(pd),
`ifdef CORE_RUN_MONITOR_CMD_STATS_EN
      .CMD(cmd),
      .CMD_CHANGES(chg),
`endif
      .RD_SEL(rd_sel),
      .BUSY(busy),
      .ALL_DONE(all_done),
      .TIMEOUT(timeout),
      .CORE_DONE_MASK(mask),
      .CYCLE_COUNT(cyc),
      .FINISH_CYCLE(fin)
   );

   task automatic sb_push(input string tag, input logic [31:0] val);
      tag_q.push_back(tag);
      val_q.push_back(val);
   endtask

   task automatic sb_check(input logic [31:0] obs);
      string       t;
      logic [31:0] v;
      compared++;
      if (val_q.size() == 0) begin
         mismatched++;
         $error("FAIL scoreboard_empty: observed %0d expected <none>", obs);
      end else begin
         t = tag_q.pop_front();
         v = val_q.pop_front();
         assert (obs === v) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, v);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_to(input int n);
      repeat (n - e) tick();
      e = n;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      e = 0;
   endtask

   task automatic read_fin(input string tag, input logic [3:0] sel, input logic [31:0] exp);
      rd_sel = sel;
      sb_push(tag, exp);
      tick();
      sb_check(fin);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      pd     = '0;
      rd_sel = 4'd0;
`ifdef CORE_RUN_MONITOR_CMD_STATS_EN
      cmd    = '0;
`endif
      tick();
      tick();

      // Reset state
      sb_push("rst_busy", 0);  sb_push("rst_done", 0); sb_push("rst_to", 0);
      sb_push("rst_mask", 0);  sb_push("rst_cyc", 0);  sb_push("rst_fin", 0);
      sb_check(busy); sb_check(all_done); sb_check(timeout);
      sb_check(mask); sb_check(cyc);      sb_check(fin);
`ifdef CORE_RUN_MONITOR_CMD_STATS_EN
      sb_push("rst_chg", 0); sb_check(chg);
`endif
      rst = 1'b0;
      tick();

      // Basic completion: cores finish on RUN edges 5, 9, 9, 20
      start_run();
      sb_push("basic_busy", 1); sb_push("basic_cyc0", 0);
      sb_check(busy); sb_check(cyc);
      run_to(5);  pd[0] = 1'b1;
      run_to(9);  pd[1] = 1'b1; pd[2] = 1'b1;
      run_to(20);
      sb_push("basic_not_done_yet", 0); sb_check(all_done);
      pd[3] = 1'b1;
      sb_push("basic_all_done", 1); sb_push("basic_busy_off", 0);
      sb_push("basic_cyc", 21);     sb_push("basic_mask", 4'hF);
      run_to(21);
      sb_check(all_done); sb_check(busy); sb_check(cyc); sb_check(mask);
      tick();
      sb_push("basic_cyc_frozen", 21); sb_check(cyc);
      read_fin("basic_fin0", 4'd0, 5);
      read_fin("basic_fin1", 4'd1, 9);
      read_fin("basic_fin2", 4'd2, 9);
      read_fin("basic_fin3", 4'd3, 20);
      read_fin("basic_sel7", 4'd7, 0);

      // Timeout with sticky mask and an ignored mid-run START
      pd = '0;
      start_run();
      sb_push("to_done_cleared", 0); sb_push("to_mask_cleared", 0);
      sb_check(all_done); sb_check(mask);
      run_to(3);  pd[0] = 1'b1;
      run_to(10); pd[1] = 1'b1; pd[2] = 1'b1;
      run_to(12); pd[0] = 1'b0;
      run_to(15); pd[0] = 1'b1;
      run_to(20);
      start = 1'b1;
      sb_push("ign_start_cyc", 21); sb_push("ign_start_mask", 4'h7);
      run_to(21);
      start = 1'b0;
      sb_check(cyc); sb_check(mask);
      run_to(49);
      sb_push("to_before_limit", 0); sb_check(timeout);
      sb_push("to_timeout", 1); sb_push("to_done", 0);
      sb_push("to_mask", 4'h7); sb_push("to_cyc", 50);
      run_to(50);
      sb_check(timeout); sb_check(all_done); sb_check(mask); sb_check(cyc);
      tick();
      sb_push("to_cyc_frozen", 50); sb_check(cyc);
      read_fin("to_fin0_sticky", 4'd0, 3);
      read_fin("to_fin2", 4'd2, 10);

      // Simultaneous completion and limit: DONE wins
      pd = 4'b0111;
      start_run();
      sb_push("sim_to_cleared", 0); sb_check(timeout);
      run_to(49);
      pd[3] = 1'b1;
      sb_push("sim_done", 1); sb_push("sim_to", 0); sb_push("sim_cyc", 50);
      run_to(50);
      sb_check(all_done); sb_check(timeout); sb_check(cyc);
      read_fin("sim_fin3", 4'd3, 49);
      read_fin("sim_fin0", 4'd0, 0);

      // Done pre-asserted before START
      pd = 4'hF;
      start_run();
      sb_push("pre_busy", 1); sb_push("pre_done_low", 0);
      sb_check(busy); sb_check(all_done);
      sb_push("pre_done", 1); sb_push("pre_cyc", 1); sb_push("pre_mask", 4'hF);
      run_to(1);
      sb_check(all_done); sb_check(cyc); sb_check(mask);
      read_fin("pre_fin1", 4'd1, 0);
      read_fin("pre_fin3", 4'd3, 0);

      // Restart clears the mask and counts from 0
      pd = '0;
      start_run();
      sb_push("rs_mask", 0); sb_push("rs_cyc", 0); sb_push("rs_busy", 1);
      sb_check(mask); sb_check(cyc); sb_check(busy);
      sb_push("rs_cyc3", 3);
      run_to(3);
      sb_check(cyc);

      // Asynchronous reset mid-run
      #2 rst = 1'b1;
      #1;
      sb_push("ar_busy", 0); sb_push("ar_cyc", 0); sb_push("ar_mask", 0); sb_push("ar_fin", 0);
      sb_check(busy); sb_check(cyc); sb_check(mask); sb_check(fin);
      @(negedge clk);
      rst = 1'b0;
      sb_push("ar_idle_busy", 0); sb_push("ar_idle_cyc", 0);
      tick();
      sb_check(busy); sb_check(cyc);

`ifdef CORE_RUN_MONITOR_CMD_STATS_EN
      // Command statistics on core 0: 1,1,2,3,3,5 then done, then more changes
      pd = '0;
      cmd[0 +: CMD_W] = 6'd1;
      cmd[CMD_W +: CMD_W] = 6'd4;
      start_run();
      cmd[0 +: CMD_W] = 6'd1; run_to(1);
      cmd[0 +: CMD_W] = 6'd1; run_to(2);
      cmd[0 +: CMD_W] = 6'd2; run_to(3);
      cmd[0 +: CMD_W] = 6'd3; run_to(4);
      cmd[0 +: CMD_W] = 6'd3; run_to(5);
      cmd[0 +: CMD_W] = 6'd5; run_to(6);
      pd[0] = 1'b1;           run_to(7);
      cmd[0 +: CMD_W] = 6'd7; run_to(8);
      cmd[0 +: CMD_W] = 6'd9; run_to(9);
      rd_sel = 4'd0;
      sb_push("cmd_core0", 3);
      run_to(10);
      sb_check(chg);
      rd_sel = 4'd1;
      sb_push("cmd_core1_static", 0);
      run_to(11);
      sb_check(chg);
      rd_sel = 4'd7;
      sb_push("cmd_sel7", 0);
      run_to(12);
      sb_check(chg);
      rd_sel = 4'd0;
      sb_push("cmd_fin0", 6);
      run_to(13);
      sb_check(fin);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
